// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the 8-bit core controller: opcodes, ALU modes, FSM states
// and the opcode-to-ALU-mode decode.
package alu_sequencer_pkg;

  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_AND  = 3'b010;
  localparam logic [2:0] OPC_OR   = 3'b011;
  localparam logic [2:0] OPC_LDI  = 3'b100;
  localparam logic [2:0] OPC_JZ   = 3'b101;
  localparam logic [2:0] OPC_JC   = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_IMM    = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  function automatic logic is_alu_op(input logic [2:0] opc);
    return (opc[2] == 1'b0);
  endfunction

  // Explicit mapping so the ALU mode encoding can diverge from the opcode field.
  function automatic logic [2:0] alu_mode_of(input logic [2:0] opc);
    logic [2:0] mode;
    case (opc)
      OPC_ADD: mode = OP_ADD;
      OPC_SUB: mode = OP_SUB;
      OPC_AND: mode = OP_AND;
      OPC_OR:  mode = OP_OR;
      default: mode = OP_ADD;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Program-memory and ALU connection between the sequencer (master) and its
// datapath peers (slave).
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       alu_enable;
  logic [2:0] alu_mode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_flag_zero;
  logic       alu_flag_carry;

  modport master (
    output imem_addr, alu_enable, alu_mode, alu_a, alu_b,
    input  imem_data, alu_out, alu_flag_zero, alu_flag_carry
  );

  modport slave (
    input  imem_addr, alu_enable, alu_mode, alu_a, alu_b,
    output imem_data, alu_out, alu_flag_zero, alu_flag_carry
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// General register file: one synchronous write port, three combinational reads
// (two ALU operands plus debug observation).
module seq_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  input  logic [1:0] raddr_dbg,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic [7:0] rdata_dbg
);

  logic [7:0] regs_r [NREGS];

  // Reset has priority so a write pending in the same cycle is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs_r[raddr_a];
  assign rdata_b   = regs_r[raddr_b];
  assign rdata_dbg = regs_r[raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Top-level controller of the 8-bit core: fetch/decode FSM driving the ALU,
// register write-back and flag-based branching.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int         NREGS    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_sequencer_if.master        bus,
  input  logic [1:0]             dbg_sel,
  output logic [7:0]             dbg_data,
  output logic                   halted
);

  logic [2:0] state_r;
  logic [7:0] pc_r;
  logic [2:0] ir_op_r;
  logic [1:0] ir_rd_r;
  logic       alu_enable_r;
  logic [2:0] alu_mode_r;
  logic [7:0] alu_a_r;
  logic [7:0] alu_b_r;
  logic       halted_r;

  logic       we_s;
  logic [7:0] wdata_s;
  logic [7:0] rdata_a_s;
  logic [7:0] rdata_b_s;
  logic       jump_taken_s;

  // Operands are read with the opcode still on imem_data so they can be
  // registered and presented to the ALU throughout DECODE.
  seq_regfile #(.NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (we_s),
    .waddr     (ir_rd_r),
    .wdata     (wdata_s),
    .raddr_a   (bus.imem_data[4:3]),
    .raddr_b   (bus.imem_data[2:1]),
    .raddr_dbg (dbg_sel),
    .rdata_a   (rdata_a_s),
    .rdata_b   (rdata_b_s),
    .rdata_dbg (dbg_data)
  );

  // Register write-back source selection and branch condition.
  always_comb begin
    we_s         = 1'b0;
    wdata_s      = bus.alu_out;
    jump_taken_s = 1'b0;
    case (state_r)
      S_WB: begin
        we_s = 1'b1;
      end
      S_IMM: begin
        if (ir_op_r == OPC_LDI) begin
          we_s    = 1'b1;
          wdata_s = bus.imem_data;
        end else begin
          we_s = 1'b0;
        end
        if (ir_op_r == OPC_JZ) begin
          jump_taken_s = bus.alu_flag_zero;
        end else if (ir_op_r == OPC_JC) begin
          jump_taken_s = bus.alu_flag_carry;
        end else begin
          jump_taken_s = 1'b0;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Main sequencing FSM; one state per cycle, HALTED holds until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_FETCH;
      pc_r         <= RESET_PC;
      ir_op_r      <= 3'b000;
      ir_rd_r      <= 2'b00;
      alu_enable_r <= 1'b0;
      alu_mode_r   <= 3'b000;
      alu_a_r      <= 8'h00;
      alu_b_r      <= 8'h00;
      halted_r     <= 1'b0;
    end else begin
      alu_enable_r <= 1'b0;
      case (state_r)
        S_FETCH: begin
          ir_op_r <= bus.imem_data[7:5];
          ir_rd_r <= bus.imem_data[4:3];
          pc_r    <= pc_r + 8'd1;
          state_r <= S_DECODE;
          if (is_alu_op(bus.imem_data[7:5])) begin
            alu_enable_r <= 1'b1;
            alu_mode_r   <= alu_mode_of(bus.imem_data[7:5]);
            alu_a_r      <= rdata_a_s;
            alu_b_r      <= rdata_b_s;
          end
        end
        S_DECODE: begin
          if (is_alu_op(ir_op_r)) begin
            state_r <= S_WB;
          end else if (ir_op_r == OPC_HALT) begin
            state_r  <= S_HALTED;
            halted_r <= 1'b1;
          end else begin
            state_r <= S_IMM;
          end
        end
        S_WB: begin
          state_r <= S_FETCH;
        end
        S_IMM: begin
          pc_r    <= jump_taken_s ? bus.imem_data : (pc_r + 8'd1);
          state_r <= S_FETCH;
        end
        S_HALTED: begin
          state_r <= S_HALTED;
        end
        default: begin
          state_r <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_addr  = pc_r;
  assign bus.alu_enable = alu_enable_r;
  assign bus.alu_mode   = alu_mode_r;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign halted         = halted_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU and ROM; expected
// ALU requests and end-of-program state are queued by the stimulus and checked by monitors.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_sel = 2'b00;
  logic [7:0] dbg_data;
  logic       halted;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // ROM model
  logic [7:0] rom [256];
  assign bus.imem_data = rom[bus.imem_addr];

  // ALU model: registered result and flags, AND/OR keep carry, SUB carry = borrow
  logic [7:0] alu_r, res_s;
  logic       z_r, c_r, c_next_s;
  always_comb begin
    res_s    = 8'h00;
    c_next_s = c_r;
    case (bus.alu_mode)
      3'b000: {c_next_s, res_s} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001: begin res_s = bus.alu_a - bus.alu_b; c_next_s = (bus.alu_a < bus.alu_b); end
      3'b010: res_s = bus.alu_a & bus.alu_b;
      3'b011: res_s = bus.alu_a | bus.alu_b;
      default: res_s = 8'h00;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_r <= 8'h00; z_r <= 1'b0; c_r <= 1'b0;
    end else if (bus.alu_enable) begin
      alu_r <= res_s; z_r <= (res_s == 8'h00); c_r <= c_next_s;
    end
  end
  assign bus.alu_out        = alu_r;
  assign bus.alu_flag_zero  = z_r;
  assign bus.alu_flag_carry = c_r;

  typedef struct { logic [2:0] mode; logic [7:0] a; logic [7:0] b; } alu_exp_t;
  typedef struct { bit is_pc; logic [1:0] idx; logic [7:0] val; string name; } st_exp_t;
  alu_exp_t alu_q[$];
  st_exp_t  st_q[$];
  event     observe_ev;
  int       checks = 0;
  int       errors = 0;
  int       pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU request monitor: every enable strobe must match the next queued op and last one cycle
  initial begin
    logic prev_en;
    alu_exp_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.alu_enable === 1'b1) begin
        pulses++;
        chk("alu_enable_width", {31'd0, prev_en}, 32'd0);
        if (alu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_alu_enable: got mode %0h a %0h b %0h expected none",
                   bus.alu_mode, bus.alu_a, bus.alu_b);
        end else begin
          e = alu_q.pop_front();
          chk("alu_mode", {29'd0, bus.alu_mode}, {29'd0, e.mode});
          chk("alu_a", {24'd0, bus.alu_a}, {24'd0, e.a});
          chk("alu_b", {24'd0, bus.alu_b}, {24'd0, e.b});
        end
      end
      prev_en = bus.alu_enable;
    end
  end

  // State monitor: on request, compare queued register/pc expectations
  initial begin
    st_exp_t e;
    forever begin
      @(observe_ev);
      while (st_q.size() > 0) begin
        e = st_q.pop_front();
        if (e.is_pc) begin
          chk(e.name, {24'd0, bus.imem_addr}, {24'd0, e.val});
        end else begin
          dbg_sel = e.idx;
          #1;
          chk(e.name, {24'd0, dbg_data}, {24'd0, e.val});
        end
      end
    end
  end

  task automatic exp_alu(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    alu_exp_t e;
    e.mode = m; e.a = a; e.b = b;
    alu_q.push_back(e);
  endtask

  task automatic exp_reg(input string n, input logic [1:0] idx, input logic [7:0] v);
    st_exp_t e;
    e.is_pc = 1'b0; e.idx = idx; e.val = v; e.name = n;
    st_q.push_back(e);
  endtask

  task automatic exp_pc(input string n, input logic [7:0] v);
    st_exp_t e;
    e.is_pc = 1'b1; e.idx = 2'b00; e.val = v; e.name = n;
    st_q.push_back(e);
  endtask

  task automatic observe();
    ->observe_ev;
    for (int i = 0; i < 4 && st_q.size() != 0; i++) #1;
    chk("observe_drained", st_q.size(), 32'd0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hE0;
  endtask

  task automatic start();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string n, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({n, "_halted"}, {31'd0, halted}, 32'd1);
    if (exp_cyc > 0) chk({n, "_halt_cycle"}, cyc, exp_cyc);
    @(negedge clk);
    chk({n, "_alu_q_empty"}, alu_q.size(), 32'd0);
  endtask

  initial begin
    int p0;

    // Reset state
    clear_rom();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc", {24'd0, bus.imem_addr}, 32'h00);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_alu_enable", {31'd0, bus.alu_enable}, 32'd0);
    chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
    chk("rst_alu_mode", {29'd0, bus.alu_mode}, 32'd0);
    for (int r = 0; r < 4; r++) exp_reg("rst_reg", r[1:0], 8'h00);
    observe();

    // T1: LDI r0,#5; LDI r1,#3; ADD r0,r1; HALT
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h05; rom[2] = 8'h88; rom[3] = 8'h03; rom[4] = 8'h02; rom[5] = 8'hE0;
    exp_alu(3'b000, 8'h05, 8'h03);
    p0 = pulses;
    start();
    wait_halt("t1", 11);
    chk("t1_pulses", pulses - p0, 32'd1);
    exp_reg("t1_r0", 2'd0, 8'h08); exp_reg("t1_r1", 2'd1, 8'h03); exp_pc("t1_pc", 8'h06);
    observe();

    // T2: 200+100 carries, JC taken to 0x40
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'hC8; rom[2] = 8'h88; rom[3] = 8'h64; rom[4] = 8'h02;
    rom[5] = 8'hC0; rom[6] = 8'h40;
    exp_alu(3'b000, 8'hC8, 8'h64);
    start();
    wait_halt("t2", 0);
    exp_reg("t2_r0", 2'd0, 8'h2C); exp_pc("t2_pc", 8'h41);
    observe();

    // T3: SUB r2,r2 gives zero, JZ taken to 0x20
    clear_rom();
    rom[0] = 8'h90; rom[1] = 8'h07; rom[2] = 8'h34; rom[3] = 8'hA0; rom[4] = 8'h20;
    exp_alu(3'b001, 8'h07, 8'h07);
    start();
    wait_halt("t3", 0);
    exp_reg("t3_r2", 2'd2, 8'h00); exp_pc("t3_pc", 8'h21);
    observe();

    // T4: 7-1 nonzero, JZ falls through
    clear_rom();
    rom[0] = 8'h90; rom[1] = 8'h07; rom[2] = 8'h98; rom[3] = 8'h01; rom[4] = 8'h36;
    rom[5] = 8'hA0; rom[6] = 8'h20;
    exp_alu(3'b001, 8'h07, 8'h01);
    start();
    wait_halt("t4", 0);
    exp_reg("t4_r2", 2'd2, 8'h06); exp_reg("t4_r3", 2'd3, 8'h01); exp_pc("t4_pc", 8'h08);
    observe();

    // T5: AND and OR, one enable pulse per op
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'hF0; rom[2] = 8'h88; rom[3] = 8'h3C; rom[4] = 8'h42;
    rom[5] = 8'h90; rom[6] = 8'hF0; rom[7] = 8'h72;
    exp_alu(3'b010, 8'hF0, 8'h3C);
    exp_alu(3'b011, 8'hF0, 8'h3C);
    p0 = pulses;
    start();
    wait_halt("t5", 0);
    chk("t5_pulses", pulses - p0, 32'd2);
    exp_reg("t5_r0", 2'd0, 8'h30); exp_reg("t5_r1", 2'd1, 8'h3C); exp_reg("t5_r2", 2'd2, 8'hFC);
    exp_pc("t5_pc", 8'h09);
    observe();

    // T6: LDI r3 at 0xFE with operand at 0xFF, then opcode from 0x00
    clear_rom();
    rom[0] = 8'hA0; rom[1] = 8'h10; rom[2] = 8'h20; rom[3] = 8'hA0; rom[4] = 8'hFE;
    rom[8'hFE] = 8'h98; rom[8'hFF] = 8'h5A;
    exp_alu(3'b001, 8'h00, 8'h00);
    start();
    wait_halt("t6", 0);
    exp_reg("t6_r3", 2'd3, 8'h5A); exp_pc("t6_pc", 8'h11);
    observe();

    // T7: reset during WB of ADD, rerun, then idle in HALTED
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h05; rom[2] = 8'h88; rom[3] = 8'h03; rom[4] = 8'h02; rom[5] = 8'hE0;
    exp_alu(3'b000, 8'h05, 8'h03);
    start();
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_rst_alu_enable", {31'd0, bus.alu_enable}, 32'd0);
    chk("t7_rst_halted", {31'd0, halted}, 32'd0);
    exp_reg("t7_rst_r0", 2'd0, 8'h00); exp_pc("t7_rst_pc", 8'h00);
    observe();
    exp_alu(3'b000, 8'h05, 8'h03);
    reset = 1'b0;
    wait_halt("t7", 11);
    p0 = pulses;
    repeat (20) @(negedge clk);
    chk("t7_idle_pulses", pulses - p0, 32'd0);
    chk("t7_idle_halted", {31'd0, halted}, 32'd1);
    exp_reg("t7_r0", 2'd0, 8'h08); exp_reg("t7_r1", 2'd1, 8'h03); exp_pc("t7_pc", 8'h06);
    observe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
